// File: rtl/ahb_slave_pkg.sv
// Shared types and constants for the AHB-Lite word-addressed memory slave.
package ahb_slave_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] data_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_LAST = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } state_t;

   // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
   function automatic logic trans_active(input logic [1:0] htrans);
      return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite slave-side bus bundle; the master modport also owns hready (interconnect side).
interface ahb_slave_mem_if;

   logic                  hsel;
   ahb_slave_pkg::addr_t  haddr;
   logic [1:0]            htrans;
   logic                  hwrite;
   logic [2:0]            hsize;
   logic [2:0]            hburst;
   logic [3:0]            hprot;
   logic                  hmastlock;
   ahb_slave_pkg::data_t  hwdata;
   logic                  hready;
   logic                  hreadyout;
   logic                  hresp;
   ahb_slave_pkg::data_t  hrdata;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata, hready,
      input  hreadyout, hresp, hrdata
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata, hready,
      output hreadyout, hresp, hrdata
   );

endinterface

// File: rtl/ahb_slave_ram.sv
// Word storage: synchronous write, asynchronous read, synchronous clear (clear wins).
module ahb_slave_ram
   import ahb_slave_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  data_t            wdata,
   input  logic [IDX_W-1:0] raddr,
   output data_t            rdata
);

   data_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave with programmable wait states and two-cycle ERROR responses.
//   state | meaning
//   IDLE  | no data phase in progress, OKAY / ready
//   WAIT  | OKAY data phase, inserting wait states (ready low)
//   LAST  | final OKAY data-phase cycle; write commits at its closing edge
//   ERR1  | first ERROR cycle (ready low)
//   ERR2  | second ERROR cycle (ready high)
module ahb_slave_mem
   import ahb_slave_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic          hclk,
   input  logic          hresetn,
   ahb_slave_mem_if.slave bus
);

   localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
   localparam logic       HAS_WAIT  = (WAIT_STATES > 0);

   state_t           state;
   logic [2:0]       wait_cnt;
   logic [IDX_W-1:0] idx_q;
   logic             write_q;
   logic             err_q;

   logic             accept;
   logic             addr_err;
   logic [29:0]      word_idx;
   logic             ram_we;
   data_t            ram_rdata;
   logic             unused_ok;

   assign word_idx = bus.haddr[31:2];
   assign accept   = bus.hsel && bus.hready && trans_active(bus.htrans);
   assign addr_err = ({2'b00, word_idx} >= 32'(DEPTH)) || (bus.hsize != HSIZE_WORD);

   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state         <= ST_IDLE;
         wait_cnt      <= 3'd0;
         idx_q         <= '0;
         write_q       <= 1'b0;
         err_q         <= 1'b0;
         bus.hreadyout <= 1'b1;
         bus.hresp     <= 1'b0;
      end else begin
         case (state)
            ST_WAIT: begin
               if (wait_cnt == 3'd0) begin
                  state         <= ST_LAST;
                  bus.hreadyout <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            ST_ERR1: begin
               state         <= ST_ERR2;
               bus.hreadyout <= 1'b1;
               bus.hresp     <= 1'b1;
            end
            default: begin
               // IDLE, LAST and ERR2 all accept the next address phase directly
               if (accept) begin
                  idx_q   <= word_idx[IDX_W-1:0];
                  write_q <= bus.hwrite;
                  err_q   <= addr_err;
                  if (addr_err) begin
                     state         <= ST_ERR1;
                     bus.hreadyout <= 1'b0;
                     bus.hresp     <= 1'b1;
                  end else if (HAS_WAIT) begin
                     state         <= ST_WAIT;
                     wait_cnt      <= WAIT_LOAD;
                     bus.hreadyout <= 1'b0;
                     bus.hresp     <= 1'b0;
                  end else begin
                     state         <= ST_LAST;
                     bus.hreadyout <= 1'b1;
                     bus.hresp     <= 1'b0;
                  end
               end else begin
                  state         <= ST_IDLE;
                  bus.hreadyout <= 1'b1;
                  bus.hresp     <= 1'b0;
               end
            end
         endcase
      end
   end

   assign ram_we = (state == ST_LAST) && write_q && !err_q;

   // Async read keeps a read right behind a same-word write coherent without forwarding.
   assign bus.hrdata = ((state == ST_LAST) && !write_q) ? ram_rdata : '0;

   ahb_slave_ram #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_ram (
      .clk   (hclk),
      .clr   (!hresetn),
      .we    (ram_we),
      .waddr (idx_q),
      .wdata (bus.hwdata),
      .raddr (idx_q),
      .rdata (ram_rdata)
   );

   assign unused_ok = ^{bus.hburst, bus.hprot, bus.hmastlock, bus.haddr[1:0]};

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: three instances (0, 2 and 3 wait states) behind one master, checked against an array model.
`timescale 1ns/1ps
module tb_ahb_slave_mem;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   int          sel;

   logic        rdy_m;
   logic        resp_m;
   logic [31:0] rdata_m;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model [3][16];

   always #5 hclk = ~hclk;

   ahb_slave_mem_if bus0 ();
   ahb_slave_mem_if bus2 ();
   ahb_slave_mem_if bus3 ();

   assign bus0.hsel = hsel && (sel == 0);
   assign bus0.haddr = haddr;
   assign bus0.htrans = htrans;
   assign bus0.hwrite = hwrite;
   assign bus0.hsize = hsize;
   assign bus0.hburst = 3'b001;
   assign bus0.hprot = 4'b0011;
   assign bus0.hmastlock = 1'b0;
   assign bus0.hwdata = hwdata;
   assign bus0.hready = rdy_m;

   assign bus2.hsel = hsel && (sel == 1);
   assign bus2.haddr = haddr;
   assign bus2.htrans = htrans;
   assign bus2.hwrite = hwrite;
   assign bus2.hsize = hsize;
   assign bus2.hburst = 3'b001;
   assign bus2.hprot = 4'b0011;
   assign bus2.hmastlock = 1'b0;
   assign bus2.hwdata = hwdata;
   assign bus2.hready = rdy_m;

   assign bus3.hsel = hsel && (sel == 2);
   assign bus3.haddr = haddr;
   assign bus3.htrans = htrans;
   assign bus3.hwrite = hwrite;
   assign bus3.hsize = hsize;
   assign bus3.hburst = 3'b001;
   assign bus3.hprot = 4'b0011;
   assign bus3.hmastlock = 1'b0;
   assign bus3.hwdata = hwdata;
   assign bus3.hready = rdy_m;

   always_comb begin
      rdy_m   = bus3.hreadyout;
      resp_m  = bus3.hresp;
      rdata_m = bus3.hrdata;
      case (sel)
         0: begin rdy_m = bus0.hreadyout; resp_m = bus0.hresp; rdata_m = bus0.hrdata; end
         1: begin rdy_m = bus2.hreadyout; resp_m = bus2.hresp; rdata_m = bus2.hrdata; end
         default: ;
      endcase
   end

   ahb_slave_mem #(.DEPTH(16), .WAIT_STATES(0)) u_ws0 (.hclk(hclk), .hresetn(hresetn), .bus(bus0.slave));
   ahb_slave_mem #(.DEPTH(16), .WAIT_STATES(2)) u_ws2 (.hclk(hclk), .hresetn(hresetn), .bus(bus2.slave));
   ahb_slave_mem #(.DEPTH(16), .WAIT_STATES(3)) u_ws3 (.hclk(hclk), .hresetn(hresetn), .bus(bus3.slave));

   function automatic int ws_of(input int s);
      return (s == 0) ? 0 : ((s == 1) ? 2 : 3);
   endfunction

   task automatic clear_model();
      for (int s = 0; s < 3; s++)
         for (int w = 0; w < 16; w++)
            model[s][w] = 32'h0;
   endtask

   task automatic bus_idle();
      hsel   = 1'b0;
      htrans = 2'b00;
      hwrite = 1'b0;
      haddr  = 32'h0;
      hsize  = 3'b010;
   endtask

   // One non-pipelined transfer; entered and left just after a rising edge.
   task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, output int waits, output logic resp_wait,
                          output logic resp_last, output logic [31:0] rdata, output logic dirty);
      int guard;
      hsel   = 1'b1;
      htrans = 2'b10;
      hwrite = wr;
      haddr  = addr;
      hsize  = size;
      @(posedge hclk); #1;
      bus_idle();
      hwdata    = wdata;
      waits     = 0;
      resp_wait = 1'b0;
      resp_last = 1'b0;
      rdata     = 32'h0;
      dirty     = 1'b0;
      guard     = 0;
      forever begin
         @(negedge hclk);
         if (rdy_m === 1'b1) begin
            resp_last = resp_m;
            rdata     = rdata_m;
            break;
         end
         waits++;
         resp_wait = resp_wait | resp_m;
         if (rdata_m !== 32'h0) dirty = 1'b1;
         guard++;
         if (guard > 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL xfer_timeout sel=%0d addr=%h: hreadyout stayed low for %0d cycles, required <= 20", sel, addr, guard);
            break;
         end
      end
      @(posedge hclk); #1;
   endtask

   task automatic test_reset();
      hresetn = 1'b0;
      hsel    = 1'b1;
      htrans  = 2'b10;
      hwrite  = 1'b1;
      haddr   = 32'h0;
      hsize   = 3'b010;
      hwdata  = 32'hFFFF_FFFF;
      repeat (3) @(posedge hclk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         @(negedge hclk);
         n_checks++;
         if (rdy_m !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout sel=%0d got %b expected 1", s, rdy_m); end
         n_checks++;
         if (resp_m !== 1'b0) begin n_fail++; $display("FAIL reset_hresp sel=%0d got %b expected 0", s, resp_m); end
         n_checks++;
         if (rdata_m !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata sel=%0d got %h expected 0", s, rdata_m); end
      end
      @(posedge hclk); #1;
      bus_idle();
      hresetn = 1'b1;
      clear_model();
      sel = 0;
   endtask

   task automatic test_basic_ws0();
      int w; logic rw, rl, d; logic [31:0] rd;
      sel = 0;
      do_xfer(1'b1, 32'h08, 3'b010, 32'hDEAD_BEEF, w, rw, rl, rd, d);
      model[0][2] = 32'hDEAD_BEEF;
      n_checks++;
      if (w !== 0 || rl !== 1'b0) begin n_fail++; $display("FAIL ws0_write waits=%0d resp=%b expected waits=0 resp=0", w, rl); end
      do_xfer(1'b0, 32'h08, 3'b010, 32'h0, w, rw, rl, rd, d);
      n_checks++;
      if (w !== 0 || rl !== 1'b0) begin n_fail++; $display("FAIL ws0_read_timing waits=%0d resp=%b expected waits=0 resp=0", w, rl); end
      n_checks++;
      if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ws0_read_data got %h expected deadbeef", rd); end
   endtask

   task automatic test_wait_states();
      int w; logic rw, rl, d; logic [31:0] rd, v;
      sel = 1;
      do_xfer(1'b0, 32'h04, 3'b010, 32'h0, w, rw, rl, rd, d);
      n_checks++;
      if (w !== 2 || rw !== 1'b0 || rl !== 1'b0) begin n_fail++; $display("FAIL ws2_read_timing waits=%0d resp=%b/%b expected waits=2 resp=0/0", w, rw, rl); end
      n_checks++;
      if (rd !== 32'h0 || d !== 1'b0) begin n_fail++; $display("FAIL ws2_read_data got %h (wait-cycle nonzero=%b) expected 0", rd, d); end
      v = $urandom;
      do_xfer(1'b1, 32'h3C, 3'b010, v, w, rw, rl, rd, d);
      model[1][15] = v;
      do_xfer(1'b0, 32'h3C, 3'b010, 32'h0, w, rw, rl, rd, d);
      n_checks++;
      if (w !== 2 || rd !== v) begin n_fail++; $display("FAIL ws2_top_word waits=%0d data=%h expected waits=2 data=%h", w, rd, v); end
   endtask

   task automatic test_error();
      int w; logic rw, rl, d; logic [31:0] rd;
      sel = 0;
      do_xfer(1'b0, 32'h40, 3'b010, 32'h0, w, rw, rl, rd, d);
      n_checks++;
      if (w !== 1 || rw !== 1'b1 || rl !== 1'b1 || rd !== 32'h0) begin
         n_fail++; $display("FAIL err_range waits=%0d resp=%b/%b data=%h expected waits=1 resp=1/1 data=0", w, rw, rl, rd);
      end
      do_xfer(1'b1, 32'h0C, 3'b000, 32'hCAFE_F00D, w, rw, rl, rd, d);
      n_checks++;
      if (w !== 1 || rw !== 1'b1 || rl !== 1'b1) begin n_fail++; $display("FAIL err_size waits=%0d resp=%b/%b expected waits=1 resp=1/1", w, rw, rl); end
      do_xfer(1'b0, 32'h0C, 3'b010, 32'h0, w, rw, rl, rd, d);
      n_checks++;
      if (rd !== 32'h0 || rl !== 1'b0) begin n_fail++; $display("FAIL err_no_write got %h resp=%b expected 0 resp=0", rd, rl); end
      sel = 2;
      do_xfer(1'b1, 32'hFFFF_FFFC, 3'b010, 32'h1234_5678, w, rw, rl, rd, d);
      n_checks++;
      if (w !== 1 || rw !== 1'b1 || rl !== 1'b1) begin n_fail++; $display("FAIL err_ws3_latency waits=%0d resp=%b/%b expected waits=1 resp=1/1", w, rw, rl); end
   endtask

   task automatic test_no_transfer();
      int w; logic rw, rl, d; logic [31:0] rd;
      logic [1:0] tr [3];
      logic       hs [3];
      tr[0] = 2'b00; hs[0] = 1'b1;
      tr[1] = 2'b01; hs[1] = 1'b1;
      tr[2] = 2'b10; hs[2] = 1'b0;
      sel = 0;
      for (int k = 0; k < 3; k++) begin
         hsel = hs[k]; htrans = tr[k]; hwrite = 1'b1; haddr = 32'h08; hsize = 3'b010;
         hwdata = 32'h0BAD_F00D;
         @(posedge hclk);
         @(negedge hclk);
         n_checks++;
         if (rdy_m !== 1'b1 || resp_m !== 1'b0 || rdata_m !== 32'h0) begin
            n_fail++; $display("FAIL no_xfer_%0d ready=%b resp=%b data=%h expected 1 0 0", k, rdy_m, resp_m, rdata_m);
         end
         @(posedge hclk); #1;
      end
      bus_idle();
      do_xfer(1'b0, 32'h08, 3'b010, 32'h0, w, rw, rl, rd, d);
      n_checks++;
      if (rd !== model[0][2]) begin n_fail++; $display("FAIL no_xfer_storage got %h expected %h", rd, model[0][2]); end
   endtask

   task automatic test_back_to_back(input int s, input logic [31:0] addr, input logic [31:0] data);
      int ww, wr_, guard; logic [31:0] rd;
      sel = s;
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = addr; hsize = 3'b010;
      @(posedge hclk); #1;
      hwrite = 1'b0;
      hwdata = data;
      ww = 0; guard = 0;
      forever begin
         @(negedge hclk);
         if (rdy_m === 1'b1) break;
         ww++; guard++;
         if (guard > 20) begin n_checks++; n_fail++; $display("FAIL b2b_write_timeout sel=%0d", s); break; end
      end
      @(posedge hclk); #1;
      bus_idle();
      wr_ = 0; guard = 0; rd = 32'h0;
      forever begin
         @(negedge hclk);
         if (rdy_m === 1'b1) begin rd = rdata_m; break; end
         wr_++; guard++;
         if (guard > 20) begin n_checks++; n_fail++; $display("FAIL b2b_read_timeout sel=%0d", s); break; end
      end
      @(posedge hclk); #1;
      model[s][addr[5:2]] = data;
      n_checks++;
      if (ww !== ws_of(s) || wr_ !== ws_of(s)) begin
         n_fail++; $display("FAIL b2b_timing sel=%0d waits=%0d/%0d expected %0d/%0d", s, ww, wr_, ws_of(s), ws_of(s));
      end
      n_checks++;
      if (rd !== data) begin n_fail++; $display("FAIL b2b_data sel=%0d got %h expected %h", s, rd, data); end
   endtask

   task automatic test_reset_mid_transfer();
      int w; logic rw, rl, d; logic [31:0] rd;
      sel = 2;
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10; hsize = 3'b010;
      @(posedge hclk); #1;
      bus_idle();
      hwdata = 32'h5A5A_5A5A;
      @(negedge hclk);
      n_checks++;
      if (rdy_m !== 1'b0) begin n_fail++; $display("FAIL mid_reset_in_wait ready=%b expected 0", rdy_m); end
      hresetn = 1'b0;
      @(posedge hclk); #1;
      n_checks++;
      if (rdy_m !== 1'b1 || resp_m !== 1'b0 || rdata_m !== 32'h0) begin
         n_fail++; $display("FAIL mid_reset_outputs ready=%b resp=%b data=%h expected 1 0 0", rdy_m, resp_m, rdata_m);
      end
      hresetn = 1'b1;
      clear_model();
      do_xfer(1'b0, 32'h10, 3'b010, 32'h0, w, rw, rl, rd, d);
      n_checks++;
      if (rd !== 32'h0 || w !== 3) begin n_fail++; $display("FAIL mid_reset_no_commit data=%h waits=%0d expected 0 and 3", rd, w); end
      sel = 0;
      do_xfer(1'b0, 32'h08, 3'b010, 32'h0, w, rw, rl, rd, d);
      n_checks++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_clears_storage got %h expected 0", rd); end
   endtask

   task automatic test_random(input int n);
      int w; logic rw, rl, d; logic [31:0] rd;
      logic wr; logic [31:0] addr, data, exp_rd; logic [2:0] size; logic err; logic [3:0] idx;
      for (int t = 0; t < n; t++) begin
         sel = $urandom_range(0, 2);
         wr  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0)
            addr = (32'($urandom_range(16, 40)) << 2) | 32'($urandom_range(0, 3));
         else
            addr = (32'($urandom_range(0, 15)) << 2);
         size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
         data = $urandom;
         err  = (addr[31:2] >= 30'd16) || (size != 3'b010);
         idx  = addr[5:2];
         exp_rd = (!err && !wr) ? model[sel][idx] : 32'h0;
         do_xfer(wr, addr, size, data, w, rw, rl, rd, d);
         n_checks++;
         if (w !== (err ? 1 : ws_of(sel))) begin
            n_fail++; $display("FAIL rand_latency t=%0d sel=%0d addr=%h got %0d expected %0d", t, sel, addr, w, err ? 1 : ws_of(sel));
         end
         n_checks++;
         if (rl !== err || rw !== (err && w > 0)) begin
            n_fail++; $display("FAIL rand_resp t=%0d sel=%0d addr=%h size=%0d got %b/%b expected %b", t, sel, addr, size, rw, rl, err);
         end
         n_checks++;
         if (rd !== exp_rd || d !== 1'b0) begin
            n_fail++; $display("FAIL rand_rdata t=%0d sel=%0d addr=%h got %h expected %h", t, sel, addr, rd, exp_rd);
         end
         if (!err && wr) model[sel][idx] = data;
         if ($urandom_range(0, 3) == 0) begin
            @(posedge hclk); #1;
         end
      end
   endtask

   initial begin
      sel    = 0;
      hwdata = 32'h0;
      bus_idle();
      hresetn = 1'b0;
      test_reset();
      test_basic_ws0();
      test_wait_states();
      test_error();
      test_no_transfer();
      test_back_to_back(0, 32'h00, 32'h1111_1111);
      test_back_to_back(1, 32'h20, $urandom);
      test_back_to_back(2, 32'h24, $urandom);
      test_reset_mid_transfer();
      test_random(200);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
